// File: rtl/axi4_burst_master.sv
// AXI4 initiator issuing one INCR burst per command, with streamed write/read data
// and a one-cycle done pulse carrying the worst response of the burst.
module axi4_burst_master #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic                    wr_valid,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    wr_ready,
  output logic                    rd_valid,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_last,
  input  logic                    rd_ready,
  output logic                    done,
  output logic [1:0]              done_resp,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic [7:0]              AWLEN,
  output logic [2:0]              AWSIZE,
  output logic [1:0]              AWBURST,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WLAST,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY,
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic [7:0]              ARLEN,
  output logic [2:0]              ARSIZE,
  output logic [1:0]              ARBURST,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RLAST,
  input  logic                    RVALID,
  output logic                    RREADY
);

  localparam int unsigned Bytes   = DATA_WIDTH / 8;
  localparam int unsigned SizeLog = $clog2(Bytes);

  typedef enum logic [2:0] {StIdle, StAw, StW, StB, StAr, StR, StErr} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              len_q, len_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [1:0]              resp_q, resp_d;
  // Keeps cmd_ready low until the first edge after reset release.
  logic                    live_q;
  logic [31:0]             end_off;
  logic                    illegal;

  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign end_off = 32'(cmd_addr[11:0]) + ((32'(cmd_len) + 32'd1) << SizeLog);
  assign illegal = (end_off > 32'd4096) || ((32'(cmd_addr) & (Bytes - 1)) != 32'd0);

  assign cmd_ready = live_q && (state_q == StIdle);

  assign AWADDR  = addr_q;
  assign AWLEN   = len_q;
  assign AWSIZE  = 3'(SizeLog);
  assign AWBURST = 2'b01;
  assign ARADDR  = addr_q;
  assign ARLEN   = len_q;
  assign ARSIZE  = 3'(SizeLog);
  assign ARBURST = 2'b01;
  assign WDATA   = wr_data;
  assign WSTRB   = '1;
  assign WLAST   = (state_q == StW) && (cnt_q == len_q);
  assign rd_data = RDATA;
  assign rd_last = (state_q == StR) && RLAST;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    resp_d    = resp_q;
    AWVALID   = 1'b0;
    ARVALID   = 1'b0;
    WVALID    = 1'b0;
    wr_ready  = 1'b0;
    BREADY    = 1'b0;
    RREADY    = 1'b0;
    rd_valid  = 1'b0;
    done      = 1'b0;
    done_resp = 2'b00;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          cnt_d   = 8'd0;
          resp_d  = 2'b00;
          state_d = illegal ? StErr : (cmd_write ? StAw : StAr);
        end
      end
      StAw: begin
        AWVALID = 1'b1;
        if (AWREADY) state_d = StW;
      end
      StW: begin
        WVALID   = wr_valid;
        wr_ready = WREADY;
        if (wr_valid && WREADY) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q) state_d = StB;
        end
      end
      StB: begin
        BREADY = 1'b1;
        if (BVALID) begin
          done      = 1'b1;
          done_resp = BRESP;
          state_d   = StIdle;
        end
      end
      StAr: begin
        ARVALID = 1'b1;
        if (ARREADY) state_d = StR;
      end
      StR: begin
        RREADY   = rd_ready;
        rd_valid = RVALID;
        if (RVALID && rd_ready) begin
          resp_d = worst(resp_q, RRESP);
          // Beat count and RLAST disagree: flag as slave error, RLAST still ends it.
          if (RLAST != (cnt_q == len_q)) resp_d = worst(resp_d, 2'b10);
          cnt_d = cnt_q + 8'd1;
          if (RLAST) begin
            done      = 1'b1;
            done_resp = resp_d;
            state_d   = StIdle;
          end
        end
      end
      StErr: begin
        done      = 1'b1;
        done_resp = 2'b10;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q <= StIdle;
      addr_q  <= '0;
      len_q   <= 8'd0;
      cnt_q   <= 8'd0;
      resp_q  <= 2'b00;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      live_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi4_burst_master.sv
// Bench for axi4_burst_master: memory slave model, write/read streams and a
// scoreboard of expected AW/AR, W, read-data and done events.
module tb_axi4_burst_master;

  logic        ACLK, ARESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wr_valid, wr_ready, rd_valid, rd_last, rd_ready, done;
  logic [31:0] wr_data, rd_data;
  logic [1:0]  done_resp;
  logic [15:0] AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0]  WSTRB;

  axi4_burst_master #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_ready(rd_ready),
    .done(done), .done_resp(done_resp),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  int checks = 0, failures = 0, cyc = 0, done_cyc = 0, w_beats = 0, aw_wait_cnt = 0;
  int acc = 0;

  logic [23:0] exp_aw[$], exp_ar[$];
  logic [32:0] exp_w[$], exp_rd[$];
  logic [1:0]  exp_done[$];
  logic [31:0] wr_q[$];
  logic [31:0] mem[16384];

  // Test knobs read by the slave/stream process.
  int          aw_stall_cfg = 0, wr_stall_pct = 0;
  logic [1:0]  rresp_cfg = 2'b00;
  logic        rd_toggle = 1'b0, no_bus = 1'b0;

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial forever begin
    @(posedge ACLK);
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event count got differs from expected", name);
  endtask

  task automatic flush_all();
    exp_aw.delete(); exp_ar.delete(); exp_w.delete(); exp_rd.delete();
    exp_done.delete(); wr_q.delete();
  endtask

  // Slave model plus write/read stream drivers: sample at negedge, update after posedge.
  logic        rst_s, aw_hs_s, aw_wait_s, w_hs_s, w_last_s, b_hs_s, ar_hs_s, r_hs_s, wr_hs_s;
  logic [15:0] aw_addr_s, ar_addr_s, waddr, raddr;
  logic [7:0]  ar_len_s, rlen;
  logic [31:0] w_data_s;
  int          aw_left = 0, wbeat = 0, rbeat = 0;

  initial begin
    AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b0; BRESP = 2'b00; ARREADY = 1'b1;
    RVALID = 1'b0; RDATA = '0; RRESP = 2'b00; RLAST = 1'b0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b1;
    waddr = '0; raddr = '0; rlen = '0;
    forever begin
      @(negedge ACLK);
      rst_s     = !ARESETn;
      aw_hs_s   = AWVALID && AWREADY;
      aw_wait_s = AWVALID && !AWREADY;
      aw_addr_s = AWADDR;
      w_hs_s    = WVALID && WREADY;
      w_data_s  = WDATA;
      w_last_s  = WLAST;
      b_hs_s    = BVALID && BREADY;
      ar_hs_s   = ARVALID && ARREADY;
      ar_addr_s = ARADDR;
      ar_len_s  = ARLEN;
      r_hs_s    = RVALID && RREADY;
      wr_hs_s   = wr_valid && wr_ready;
      @(posedge ACLK);
      #1;
      if (rst_s) begin
        BVALID = 1'b0; RVALID = 1'b0; RLAST = 1'b0; aw_left = 0; wbeat = 0; rbeat = 0;
      end else begin
        if (aw_hs_s) begin
          waddr = aw_addr_s; wbeat = 0; aw_left = 0;
        end else if (aw_wait_s) aw_left++;
        if (b_hs_s) BVALID = 1'b0;
        if (w_hs_s) begin
          mem[int'(waddr >> 2) + wbeat] = w_data_s;
          wbeat++;
          if (w_last_s) begin BVALID = 1'b1; BRESP = 2'b00; end
        end
        if (r_hs_s) begin
          if (RLAST) RVALID = 1'b0;
          else begin
            rbeat++;
            RDATA = mem[int'(raddr >> 2) + rbeat];
            RLAST = (rbeat == int'(rlen));
          end
        end
        if (ar_hs_s) begin
          raddr = ar_addr_s; rlen = ar_len_s; rbeat = 0;
          RVALID = 1'b1; RDATA = mem[int'(raddr >> 2)]; RLAST = (rlen == 8'd0);
          RRESP = rresp_cfg;
        end
        if (wr_hs_s && wr_q.size() > 0) void'(wr_q.pop_front());
      end
      AWREADY  = (aw_left >= aw_stall_cfg);
      wr_valid = (wr_q.size() > 0) && ($urandom_range(0, 99) >= wr_stall_pct);
      wr_data  = (wr_q.size() > 0) ? wr_q[0] : 32'd0;
      rd_ready = rd_toggle ? !rd_ready : 1'b1;
    end
  end

  // Monitor / scoreboard.
  logic        aw_seen = 1'b0, prev_aw_wait = 1'b0;
  logic [15:0] prev_awaddr = '0;
  logic [7:0]  prev_awlen = '0;

  initial forever begin
    @(negedge ACLK);
    if (!ARESETn) begin
      aw_seen = 1'b0;
      prev_aw_wait = 1'b0;
    end else begin
      if (no_bus) chk("no_bus_traffic", 64'(AWVALID | ARVALID), 64'd0);
      if (WVALID) chk("wvalid_after_aw", 64'(aw_seen), 64'd1);
      if (WVALID && WREADY) begin
        if (exp_w.size() == 0) miss("w_unexpected");
        else chk("w_data_last", 64'({WLAST, WDATA}), 64'(exp_w.pop_front()));
        chk("wstrb", 64'(WSTRB), 64'hF);
        w_beats++;
        if (WLAST) aw_seen = 1'b0;
      end
      if (AWVALID && prev_aw_wait) begin
        chk("aw_stable_addr", 64'(AWADDR), 64'(prev_awaddr));
        chk("aw_stable_len", 64'(AWLEN), 64'(prev_awlen));
      end
      if (AWVALID && !AWREADY) aw_wait_cnt++;
      if (AWVALID && AWREADY) begin
        if (exp_aw.size() == 0) miss("aw_unexpected");
        else chk("aw_addr_len", 64'({AWADDR, AWLEN}), 64'(exp_aw.pop_front()));
        chk("aw_size_burst", 64'({AWSIZE, AWBURST}), 64'({3'd2, 2'b01}));
        aw_seen = 1'b1;
      end
      if (ARVALID && ARREADY) begin
        if (exp_ar.size() == 0) miss("ar_unexpected");
        else chk("ar_addr_len", 64'({ARADDR, ARLEN}), 64'(exp_ar.pop_front()));
        chk("ar_size_burst", 64'({ARSIZE, ARBURST}), 64'({3'd2, 2'b01}));
      end
      if (rd_valid && rd_ready) begin
        if (exp_rd.size() == 0) miss("rd_unexpected");
        else chk("rd_data_last", 64'({rd_last, rd_data}), 64'(exp_rd.pop_front()));
      end
      if (done) begin
        done_cyc = cyc;
        if (exp_done.size() == 0) miss("done_unexpected");
        else chk("done_resp", 64'(done_resp), 64'(exp_done.pop_front()));
      end
      prev_aw_wait = AWVALID && !AWREADY;
      prev_awaddr  = AWADDR;
      prev_awlen   = AWLEN;
    end
  end

  task automatic do_cmd(input logic wr, input logic [15:0] addr, input logic [7:0] len,
                        output int acc_cyc);
    bit ok = 1'b0;
    @(posedge ACLK);
    #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    acc_cyc = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge ACLK);
      if (cmd_ready) begin ok = 1'b1; acc_cyc = cyc; end
    end
    if (!ok) miss("cmd_accept_timeout");
    @(posedge ACLK);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_write(input logic [15:0] addr, input logic [7:0] len, input logic [31:0] base,
                           input logic [31:0] step, input logic [1:0] resp, output int acc_cyc);
    logic [31:0] d;
    for (int i = 0; i <= int'(len); i++) begin
      d = base + 32'(i) * step;
      wr_q.push_back(d);
      exp_w.push_back({i == int'(len), d});
    end
    exp_aw.push_back({addr, len});
    exp_done.push_back(resp);
    do_cmd(1'b1, addr, len, acc_cyc);
  endtask

  task automatic run_read(input logic [15:0] addr, input logic [7:0] len, input logic [31:0] base,
                          input logic [31:0] step, input logic [1:0] resp, output int acc_cyc);
    for (int i = 0; i <= int'(len); i++) exp_rd.push_back({i == int'(len), base + 32'(i) * step});
    exp_ar.push_back({addr, len});
    exp_done.push_back(resp);
    do_cmd(1'b0, addr, len, acc_cyc);
  endtask

  task automatic wait_quiet(input int budget);
    bit quiet = 1'b0;
    for (int i = 0; i < budget && !quiet; i++) begin
      @(negedge ACLK);
      quiet = (exp_aw.size() + exp_ar.size() + exp_w.size() + exp_rd.size()
               + exp_done.size()) == 0;
    end
    if (!quiet) begin
      miss("completion_timeout");
      flush_all();
    end
  endtask

  initial begin
    ARESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("reset_outputs", 64'({cmd_ready, AWVALID, WVALID, wr_ready, BREADY, ARVALID, RREADY,
                              rd_valid, done, done_resp}), 64'd0);
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("cmd_ready_before_edge", 64'(cmd_ready), 64'd0);
    @(negedge ACLK);
    chk("cmd_ready_after_release", 64'(cmd_ready), 64'd1);

    // Four-beat write, zero-wait slave, then read back.
    run_write(16'h0010, 8'd3, 32'd1, 32'd1, 2'b00, acc);
    wait_quiet(100);
    chk("write_latency", 64'(done_cyc - acc), 64'd6);
    run_read(16'h0010, 8'd3, 32'd1, 32'd1, 2'b00, acc);
    wait_quiet(100);

    // AWREADY held low for 5 cycles.
    aw_stall_cfg = 5;
    aw_wait_cnt = 0;
    @(posedge ACLK);
    run_write(16'h0100, 8'd0, 32'hAB, 32'd0, 2'b00, acc);
    wait_quiet(100);
    chk("aw_stall_cycles", 64'(aw_wait_cnt), 64'd5);
    aw_stall_cfg = 0;

    // Illegal commands: 4 KB crossing and misaligned.
    no_bus = 1'b1;
    exp_done.push_back(2'b10);
    do_cmd(1'b1, 16'h0FF8, 8'd3, acc);
    @(negedge ACLK);
    chk("err_done_pulse", 64'({done, done_resp}), 64'b110);
    @(negedge ACLK);
    chk("err_done_once", 64'(done), 64'd0);
    wait_quiet(50);
    exp_done.push_back(2'b10);
    do_cmd(1'b0, 16'h0002, 8'd0, acc);
    wait_quiet(50);
    no_bus = 1'b0;

    // Ends exactly on the 4 KB boundary: legal.
    run_write(16'h0FF0, 8'd3, 32'h11, 32'd1, 2'b00, acc);
    wait_quiet(100);

    // Single-beat read, SLVERR, rd_ready toggling.
    rresp_cfg = 2'b10;
    rd_toggle = 1'b1;
    run_read(16'h0010, 8'd0, 32'd1, 32'd0, 2'b10, acc);
    wait_quiet(100);
    rresp_cfg = 2'b00;
    rd_toggle = 1'b0;

    // Reset during beat 2 of an 8-beat write.
    w_beats = 0;
    run_write(16'h0300, 8'd7, 32'h50, 32'd1, 2'b00, acc);
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 50 && !hit; i++) begin
        @(negedge ACLK);
        hit = (w_beats >= 1);
      end
      if (!hit) miss("reset_beat_wait");
    end
    @(posedge ACLK);
    #1;
    ARESETn = 1'b0;
    flush_all();
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("post_reset_outputs", 64'({AWVALID, WVALID, ARVALID, BREADY, RREADY, wr_ready, rd_valid,
                                   done, cmd_ready}), 64'd0);
    run_write(16'h0200, 8'd0, 32'h77, 32'd0, 2'b00, acc);
    wait_quiet(100);
    run_read(16'h0200, 8'd0, 32'h77, 32'd0, 2'b00, acc);
    wait_quiet(100);

    // 256-beat write with a stalling source, then read back the last two beats.
    wr_stall_pct = 40;
    w_beats = 0;
    run_write(16'h0400, 8'd255, 32'd7, 32'd3, 2'b00, acc);
    wait_quiet(3000);
    wr_stall_pct = 0;
    chk("long_write_beats", 64'(w_beats), 64'd256);
    run_read(16'h07F8, 8'd1, 32'd769, 32'd3, 2'b00, acc);
    wait_quiet(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
